// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI responder that oversamples an externally driven SCLK / CS_N / MOSI in
//   the i_clk domain. MOSI is deserialized MSB first into o_rx_data, and a
//   word taken from a one-deep transmit holding buffer is serialized onto
//   o_miso. Supports all four SPI modes through CPOL / CPHA and any number of
//   back-to-back frames inside one chip-select assertion.
//
// Parameters
//   WIDTH  bits per frame (>= 2)
//   CPOL   SCLK idle level
//   CPHA   0: sample on leading edge, shift on trailing edge
//          1: shift on leading edge, sample on trailing edge
//
// Ports
//   i_clk, i_reset          system clock, asynchronous active-low reset
//   i_sclk, i_cs_n, i_mosi  SPI pins from the master (asynchronous)
//   o_miso, o_miso_oe       SPI data out and its output enable
//   i_tx_data, i_tx_valid   transmit word and its valid
//   o_tx_ready              transmit holding buffer empty
//   o_rx_data, o_rx_valid   last received word and its one-cycle update pulse
//   o_busy                  chip select asserted (synchronized)
//   o_underrun              one-cycle pulse: load found the buffer empty
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int WIDTH = 8,
    parameter bit CPOL  = 1'b0,
    parameter bit CPHA  = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sclk,
    input  logic             i_cs_n,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_busy,
    output logic             o_underrun
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic               r_cs_s1, r_cs_s2, r_cs_d;
    logic               r_mosi_s1, r_mosi_s2;

    logic [CNT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_rx_shift;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_rx_valid;
    logic [WIDTH-1:0]   r_tx_shift;
    logic [WIDTH-1:0]   r_buf;
    logic               r_buf_vld;
    logic               r_underrun;

    logic               w_sclk_chg, w_lead, w_trail;
    logic               w_cs_fall, w_cs_rise;
    logic               w_active, w_do_sample, w_do_shift;
    logic               w_last, w_load, w_wr;

    // Two-flop synchronizers plus a history flop for edge detection. The
    // synchronizers reset to the idle pin levels so release of reset never
    // looks like an edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sclk_s1 <= CPOL;
            r_sclk_s2 <= CPOL;
            r_sclk_d  <= CPOL;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_d    <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= i_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_cs_s1   <= i_cs_n;
            r_cs_s2   <= r_cs_s1;
            r_cs_d    <= r_cs_s2;
            r_mosi_s1 <= i_mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_sclk_chg = r_sclk_s2 ^ r_sclk_d;
    assign w_lead     = w_sclk_chg && (r_sclk_s2 != CPOL);
    assign w_trail    = w_sclk_chg && (r_sclk_s2 == CPOL);
    assign w_cs_fall  = r_cs_d && !r_cs_s2;
    assign w_cs_rise  = !r_cs_d && r_cs_s2;

    // SCLK edges count only inside an active frame; the CS-rise cycle aborts.
    assign w_active    = (r_state == S_ACTIVE) && !w_cs_rise;
    assign w_do_sample = w_active && (CPHA ? w_trail : w_lead);
    assign w_do_shift  = w_active && (CPHA ? w_lead : w_trail);
    assign w_last      = (r_bit_cnt == CNT_W'(WIDTH - 1));

    // A shift edge with the bit counter at zero starts a frame: for CPHA=1 it
    // is the first leading edge, for CPHA=0 the trailing edge right after the
    // last sample. CPHA=0 additionally loads on the CS falling edge.
    assign w_load = (!CPHA && (r_state == S_IDLE) && w_cs_fall) ||
                    (w_do_shift && (r_bit_cnt == '0));
    assign w_wr   = i_tx_valid && !r_buf_vld;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_cs_fall) w_state_next = S_ACTIVE;
            S_ACTIVE: if (w_cs_rise) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_shift <= '0;
            r_buf      <= '0;
            r_buf_vld  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;

            // Transmit: the buffer cannot be written while full, so a load
            // from a full buffer never collides with a write. A write into
            // an empty buffer during a load bypasses straight to the shifter.
            if (w_load) begin
                if (r_buf_vld) begin
                    r_tx_shift <= r_buf;
                    r_buf_vld  <= 1'b0;
                end else if (i_tx_valid) begin
                    r_tx_shift <= i_tx_data;
                end else begin
                    r_tx_shift <= '0;
                    r_underrun <= 1'b1;
                end
            end else begin
                if (w_do_shift) r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
                if (w_wr) begin
                    r_buf     <= i_tx_data;
                    r_buf_vld <= 1'b1;
                end
            end
            // A word already in the shifter is dropped on deselect.
            if (w_cs_rise) r_tx_shift <= '0;

            // Receive
            if (w_cs_rise || (r_state == S_IDLE)) begin
                r_bit_cnt <= '0;
            end else if (w_do_sample) begin
                r_rx_shift <= {r_rx_shift[WIDTH-2:0], r_mosi_s2};
                if (w_last) begin
                    r_bit_cnt  <= '0;
                    r_rx_data  <= {r_rx_shift[WIDTH-2:0], r_mosi_s2};
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_miso     = r_tx_shift[WIDTH-1] && (r_state == S_ACTIVE);
    assign o_miso_oe  = (r_state == S_ACTIVE);
    assign o_busy     = (r_state == S_ACTIVE);
    assign o_tx_ready = !r_buf_vld;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//   Two instances: index 0 is SPI mode 0 (CPOL=0, CPHA=0), index 1 is mode 3
//   (CPOL=1, CPHA=1). A bus-functional master drives the pins; expected
//   receive words are queued at frame start and popped by a monitor on each
//   o_rx_valid pulse. The transmit side is modelled as a one-deep buffer that
//   each load either drains or finds empty (counting an underrun).
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int W = 8;
    localparam int H = 5;   // SCLK half period in i_clk cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk [2];
    logic       cs_n [2];
    logic       mosi [2];
    logic       tx_valid [2];
    logic [7:0] tx_data [2];
    wire        miso [2];
    wire        oe [2];
    wire        tx_ready [2];
    wire        rx_valid [2];
    wire        busy [2];
    wire        unr [2];
    wire  [7:0] rx_data [2];

    always #5 clk = ~clk;

    spi_slave #(.WIDTH(W), .CPOL(1'b0), .CPHA(1'b0)) u_mode0 (
        .i_clk(clk), .i_reset(rst_n), .i_sclk(sclk[0]), .i_cs_n(cs_n[0]),
        .i_mosi(mosi[0]), .o_miso(miso[0]), .o_miso_oe(oe[0]),
        .i_tx_data(tx_data[0]), .i_tx_valid(tx_valid[0]), .o_tx_ready(tx_ready[0]),
        .o_rx_data(rx_data[0]), .o_rx_valid(rx_valid[0]), .o_busy(busy[0]),
        .o_underrun(unr[0])
    );

    spi_slave #(.WIDTH(W), .CPOL(1'b1), .CPHA(1'b1)) u_mode3 (
        .i_clk(clk), .i_reset(rst_n), .i_sclk(sclk[1]), .i_cs_n(cs_n[1]),
        .i_mosi(mosi[1]), .o_miso(miso[1]), .o_miso_oe(oe[1]),
        .i_tx_data(tx_data[1]), .i_tx_valid(tx_valid[1]), .o_tx_ready(tx_ready[1]),
        .o_rx_data(rx_data[1]), .o_rx_valid(rx_valid[1]), .o_busy(busy[1]),
        .o_underrun(unr[1])
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_rx0[$];
    logic [7:0] exp_rx1[$];
    logic [7:0] e0, e1;
    logic       mbuf_vld [2];
    logic [7:0] mbuf [2];
    int         exp_unr [2];
    int         act_unr [2];
    logic [7:0] last_rx [2];

    // Per-session stimulus plan
    logic [7:0] s_mw [4];   // MOSI word per frame
    logic       s_wr [4];   // write a TX word during this frame
    logic [7:0] s_ww [4];   // the word to write

    task automatic check(input string name, input int m, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (mode%0d): got %0h, expected %0h", name, (m == 0) ? 0 : 3, act, exp);
        end
    endtask

    // Reference model of one load: drain the buffer or report an underrun.
    function automatic logic [7:0] mload(input int m);
        logic [7:0] r;
        if (mbuf_vld[m]) begin
            r = mbuf[m];
            mbuf_vld[m] = 1'b0;
        end else begin
            r = 8'h00;
            exp_unr[m]++;
        end
        return r;
    endfunction

    // Receive scoreboard and underrun counter
    always @(negedge clk) begin
        if (rx_valid[0] === 1'b1) begin
            if (exp_rx0.size() == 0) check("rx_unexpected_pulse", 0, {31'b0, rx_valid[0]}, 0);
            else begin
                e0 = exp_rx0.pop_front();
                check("rx_data", 0, {24'b0, rx_data[0]}, {24'b0, e0});
                last_rx[0] = e0;
            end
        end
        if (rx_valid[1] === 1'b1) begin
            if (exp_rx1.size() == 0) check("rx_unexpected_pulse", 1, {31'b0, rx_valid[1]}, 0);
            else begin
                e1 = exp_rx1.pop_front();
                check("rx_data", 1, {24'b0, rx_data[1]}, {24'b0, e1});
                last_rx[1] = e1;
            end
        end
        if (unr[0] === 1'b1) act_unr[0]++;
        if (unr[1] === 1'b1) act_unr[1]++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input int m, input logic [7:0] w);
        check("tx_ready_before_write", m, {31'b0, tx_ready[m]}, 1);
        tx_data[m]  = w;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
        mbuf[m]     = w;
        mbuf_vld[m] = 1'b1;
    endtask

    task automatic check_reset_vals(input int m);
        check("rst_miso", m, {31'b0, miso[m]}, 0);
        check("rst_miso_oe", m, {31'b0, oe[m]}, 0);
        check("rst_rx_data", m, {24'b0, rx_data[m]}, 0);
        check("rst_rx_valid", m, {31'b0, rx_valid[m]}, 0);
        check("rst_tx_ready", m, {31'b0, tx_ready[m]}, 1);
        check("rst_busy", m, {31'b0, busy[m]}, 0);
        check("rst_underrun", m, {31'b0, unr[m]}, 0);
    endtask

    // One CS assertion: nfr full frames followed by an optional aborted frame
    // of abort_bits bits. byp drives i_tx_valid exactly in the CS-fall load
    // cycle (mode 0 only).
    task automatic session(input int m, input int nfr, input int abort_bits,
                           input logic byp, input logic [7:0] bw);
        logic [7:0] exp_w [5];
        logic [7:0] got;
        int         nb;
        cs_n[m] = 1'b0;
        mosi[m] = s_mw[0][7];
        if (m == 0) begin
            if (byp) begin
                wait_clk(2);
                tx_data[m]  = bw;
                tx_valid[m] = 1'b1;
                @(negedge clk);
                tx_valid[m] = 1'b0;
                exp_w[0] = bw;
                wait_clk(3);
                check("tx_ready_after_bypass", m, {31'b0, tx_ready[m]}, 1);
                check("underrun_at_bypass_load", m, act_unr[m], exp_unr[m]);
                check("busy_in_frame", m, {31'b0, busy[m]}, 1);
            end else begin
                exp_w[0] = mload(m);
                wait_clk(6);
            end
        end else begin
            wait_clk(6);
        end
        for (int f = 0; f <= nfr; f++) begin
            nb = (f < nfr) ? W : abort_bits;
            if (nb == 0) break;
            if (f < nfr) begin
                if (m == 0) exp_rx0.push_back(s_mw[f]);
                else        exp_rx1.push_back(s_mw[f]);
            end
            got = 8'h00;
            for (int b = 0; b < nb; b++) begin
                if (m == 0) begin
                    sclk[m] = 1'b1;
                    got = {got[6:0], miso[m]};
                    wait_clk(H);
                    sclk[m] = 1'b0;
                    if (b < W - 1)  mosi[m] = s_mw[f][6 - b];
                    else if (f < 3) mosi[m] = s_mw[f + 1][7];
                    else            mosi[m] = 1'b0;
                end else begin
                    if (b == 0) exp_w[f] = mload(m);
                    sclk[m] = 1'b0;
                    mosi[m] = s_mw[f][7 - b];
                    wait_clk(H);
                    sclk[m] = 1'b1;
                    got = {got[6:0], miso[m]};
                end
                if (b == 3 && s_wr[f] && !mbuf_vld[m]) begin
                    tx_write(m, s_ww[f]);
                    wait_clk(H - 1);
                end else begin
                    wait_clk(H);
                end
            end
            if (f < nfr) begin
                check("miso_word", m, {24'b0, got}, {24'b0, exp_w[f]});
                if (m == 0) exp_w[f + 1] = mload(m);
            end
        end
        wait_clk(H);
        cs_n[m] = 1'b1;
        mosi[m] = 1'b0;
        wait_clk(8);
        check("underrun_count", m, act_unr[m], exp_unr[m]);
        check("rx_pulses_outstanding", m, (m == 0) ? exp_rx0.size() : exp_rx1.size(), 0);
        check("rx_data_hold", m, {24'b0, rx_data[m]}, {24'b0, last_rx[m]});
        check("tx_ready_idle", m, {31'b0, tx_ready[m]}, {31'b0, !mbuf_vld[m]});
        check("busy_idle", m, {31'b0, busy[m]}, 0);
        check("miso_oe_idle", m, {31'b0, oe[m]}, 0);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 4; i++) begin
            s_mw[i] = 8'h00;
            s_wr[i] = 1'b0;
            s_ww[i] = 8'h00;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected the test to complete");
        $fatal(1);
    end

    initial begin
        int m, nfr, ab;
        for (int i = 0; i < 2; i++) begin
            cs_n[i] = 1'b1;
            mosi[i] = 1'b0;
            tx_valid[i] = 1'b0;
            tx_data[i] = 8'h00;
            mbuf_vld[i] = 1'b0;
            mbuf[i] = 8'h00;
            exp_unr[i] = 0;
            act_unr[i] = 0;
            last_rx[i] = 8'h00;
        end
        sclk[0] = 1'b0;
        sclk[1] = 1'b1;
        rst_n = 1'b0;
        wait_clk(3);
        check_reset_vals(0);
        check_reset_vals(1);
        rst_n = 1'b1;
        wait_clk(4);

        // Mode 0: preloaded 0xA5 out, 0x3C in
        clear_plan();
        s_mw[0] = 8'h3C;
        tx_write(0, 8'hA5);
        wait_clk(2);
        check("tx_ready_full", 0, {31'b0, tx_ready[0]}, 0);
        session(0, 1, 0, 1'b0, 8'h00);

        // Mode 3: two frames, 0x81 preloaded, 0x7E written during frame 1
        clear_plan();
        s_mw[0] = 8'h96; s_mw[1] = 8'h4B;
        s_wr[0] = 1'b1;  s_ww[0] = 8'h7E;
        tx_write(1, 8'h81);
        wait_clk(2);
        session(1, 2, 0, 1'b0, 8'h00);

        // Mode 3: nothing written, one underrun and 0x00 out
        clear_plan();
        s_mw[0] = 8'hE7;
        session(1, 1, 0, 1'b0, 8'h00);

        // Mode 0: abort after 5 bits, then a clean frame
        clear_plan();
        s_mw[0] = 8'hFF;
        session(0, 0, 5, 1'b0, 8'h00);
        clear_plan();
        s_mw[0] = 8'h69;
        tx_write(0, 8'hD2);
        wait_clk(2);
        session(0, 1, 0, 1'b0, 8'h00);

        // Mode 0: write lands in the CS-fall load cycle
        clear_plan();
        s_mw[0] = 8'h11;
        session(0, 1, 0, 1'b1, 8'h5A);

        // Reset asserted mid-frame
        clear_plan();
        tx_write(0, 8'h33);
        wait_clk(2);
        cs_n[0] = 1'b0;
        mosi[0] = 1'b1;
        wait_clk(6);
        for (int b = 0; b < 3; b++) begin
            sclk[0] = 1'b1;
            wait_clk(H);
            sclk[0] = 1'b0;
            wait_clk(H);
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals(0);
        check_reset_vals(1);
        for (int i = 0; i < 2; i++) begin
            mbuf_vld[i] = 1'b0;
            last_rx[i] = 8'h00;
        end
        cs_n[0] = 1'b1;
        mosi[0] = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        s_mw[0] = 8'hC3;
        tx_write(0, 8'h3C);
        wait_clk(2);
        session(0, 1, 0, 1'b0, 8'h00);

        // Randomized sessions
        for (int it = 0; it < 12; it++) begin
            m   = int'($urandom_range(0, 1));
            nfr = int'($urandom_range(1, 3));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            for (int i = 0; i < 4; i++) begin
                s_mw[i] = 8'($urandom);
                s_wr[i] = 1'($urandom);
                s_ww[i] = 8'($urandom);
            end
            if (!mbuf_vld[m] && ($urandom_range(0, 1) == 1)) begin
                tx_write(m, 8'($urandom));
                wait_clk(2);
            end
            session(m, nfr, ab, 1'b0, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder (slave) for the FPGA side of the SPI link. Oversamples an externally driven SCLK/CS_N/MOSI in the i_clk domain, deserializes MOSI into parallel words and serializes a parallel transmit word onto MISO. It is the counterpart of the team's SPI master, which uses the shared `counter` for bit timing. It sits between the external SPI pins and the register/FIFO logic, with a valid/ready transmit port and a pulse-valid receive port.

## Interface
- WIDTH, 8, bits per frame (≥2)
- CPOL, 0, SCLK idle level
- CPHA, 0, 0: sample on leading edge, shift on trailing edge; 1: shift on leading edge, sample on trailing edge
- i_clk  in  1  system clock; clock i_clk
- i_reset  in  1  reset i_reset, asynchronous, active-low
- i_sclk  in  1  SPI clock from master (asynchronous)
- i_cs_n  in  1  chip select, active-low (asynchronous)
- i_mosi  in  1  master-out data (asynchronous)
- o_miso  out  1  slave-out data
- o_miso_oe  out  1  MISO output enable (synchronized, inverted CS)
- i_tx_data  in  WIDTH  next word to transmit
- i_tx_valid  in  1  i_tx_data valid
- o_tx_ready  out  1  TX holding buffer empty
- o_rx_data  out  WIDTH  last complete received word
- o_rx_valid  out  1  one-cycle pulse: o_rx_data updated
- o_busy  out  1  CS asserted (synchronized)
- o_underrun  out  1  one-cycle pulse: frame started with empty TX buffer

## Operation
- Two-flop synchronizers on i_sclk, i_cs_n and i_mosi, plus one history flop on SCLK and CS for edge detection. All logic runs on i_clk.
- Leading edge is the SCLK transition away from CPOL; trailing edge is the transition back.
- States:
  - IDLE: synced CS high.
  - ACTIVE: synced CS low.
  - IDLE→ACTIVE on synced CS falling edge.
  - ACTIVE→IDLE on synced CS rising edge, from any bit position.
- Bit counter, 0..WIDTH-1, width $clog2(WIDTH)+1:
  - Increments on each sample edge.
  - On the WIDTH-th sample it wraps to 0 and the frame completes.
  - Multiple back-to-back frames within one CS assertion are supported.
- RX path:
  - Shift register, MSB first; synced MOSI shifts in on each sample edge.
  - On frame completion: o_rx_data ← assembled word and o_rx_valid pulses for 1 cycle.
  - o_rx_data holds its value until the next completed frame.
- TX path:
  - Holding buffer is written when i_tx_valid && o_tx_ready; o_tx_ready = buffer empty.
  - Load (buffer → shift register, MSB on o_miso) occurs:
    - CPHA=0: on CS falling edge, and on the trailing edge following the last sample of a frame.
    - CPHA=1: on the first leading edge of each frame.
  - Non-load shift edges shift the register left and drive its MSB on o_miso.
  - Empty buffer at a load: shift register ← 0 and o_underrun pulses.
  - Buffer write in the same cycle as a load with an empty buffer: the word bypasses into the shift register, the buffer stays empty, no underrun.
- CS rising edge mid-frame:
  - Frame aborted, bit counter → 0, no o_rx_valid.
  - A word already loaded into the shift register is discarded; the holding buffer is kept.
- IDLE: o_miso = 0 and o_miso_oe = 0.
- SCLK edges while IDLE are ignored.

## Timing
- Reset values:
  - o_miso 0, o_miso_oe 0, o_rx_data 0, o_rx_valid 0, o_tx_ready 1, o_busy 0, o_underrun 0.
  - Internal counter, shift registers and buffer cleared.
- Input-to-detect latency: 3 i_clk cycles from a pin edge to its registered action.
- o_rx_valid asserts 1 cycle after the detected final sample edge.
- o_miso updates 1 cycle after a detected shift/load edge; the master sees it ≤4 i_clk after its SCLK edge.
- Master constraints:
  - SCLK high and low phases each ≥ 3 i_clk periods, i.e. f_sclk ≤ f_clk/6.
  - CS fall to first SCLK edge ≥ 4 i_clk.
- o_busy and o_miso_oe follow synced CS with 3-cycle latency.

## Test plan
- Mode 0, WIDTH=8, tx 0xA5 preloaded, master sends 0x3C: o_rx_data=0x3C with a single o_rx_valid pulse; master receives 0xA5; o_tx_ready=1 after the load.
- Mode 3 (CPOL=1, CPHA=1), two back-to-back frames under one CS, tx 0x81 then 0x7E written during frame 1: master receives 0x81, 0x7E; two o_rx_valid pulses; no underrun.
- No tx write before CS fall: o_underrun pulses once and the master receives 0x00.
- CS raised after 5 bits of mode 0: no o_rx_valid; next full frame receives correctly with the bit counter restarted.
- i_tx_valid asserted in the exact cycle of the CS-fall load, data 0x5A: MISO sends 0x5A, no underrun, o_tx_ready stays 1.
- i_reset low mid-frame: all outputs return to reset values immediately; first full frame after release completes normally.
